load_ctrl: RTL and testbench

Load-side memory controller for the single-cycle core. It accepts one load request from the execute stage and issues a single-beat AXI4 read. It aligns the returned 64-bit beat to the requested byte offset and drives the aligned value through a `sign_extend` instance. It returns the extended or zero-extended result with a one-cycle completion pulse, and holds the core stalled via `busy` for the whole transaction.

---
 rtl/load_ctrl_pkg.sv | 57 +++++
 rtl/load_ctrl_sign_extend.sv | 20 ++
 rtl/load_ctrl.sv | 108 ++++++++++
 tb/tb_load_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/load_ctrl_pkg.sv
// rtl/load_ctrl_pkg.sv - shared encodings and helpers for the load-side controller
package load_ctrl_pkg;

    localparam int REG_W        = 64;
    localparam int OP_WIDTH_BUS = 2;

    typedef logic [OP_WIDTH_BUS-1:0] op_width_t;

    localparam op_width_t OP_WIDTH_1_REG = 2'd0;
    localparam op_width_t OP_WIDTH_2_REG = 2'd1;
    localparam op_width_t OP_WIDTH_4_REG = 2'd2;
    localparam op_width_t OP_WIDTH_8_REG = 2'd3;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_ADDR = 2'd1,
        LD_DATA = 2'd2,
        LD_RESP = 2'd3
    } ld_state_t;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [2:0] AXI_SIZE_1 = 3'd0;
    localparam logic [2:0] AXI_SIZE_2 = 3'd1;
    localparam logic [2:0] AXI_SIZE_4 = 3'd2;
    localparam logic [2:0] AXI_SIZE_8 = 3'd3;

    function automatic logic [2:0] width_to_size(input op_width_t w);
        case (w)
            OP_WIDTH_1_REG: width_to_size = AXI_SIZE_1;
            OP_WIDTH_2_REG: width_to_size = AXI_SIZE_2;
            OP_WIDTH_4_REG: width_to_size = AXI_SIZE_4;
            default:        width_to_size = AXI_SIZE_8;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input op_width_t w);
        case (w)
            OP_WIDTH_1_REG: align_mask = 3'b000;
            OP_WIDTH_2_REG: align_mask = 3'b001;
            OP_WIDTH_4_REG: align_mask = 3'b011;
            default:        align_mask = 3'b111;
        endcase
    endfunction

    function automatic logic [REG_W-1:0] zero_extend(input logic [REG_W-1:0] d, input op_width_t w);
        case (w)
            OP_WIDTH_1_REG: zero_extend = {56'd0, d[7:0]};
            OP_WIDTH_2_REG: zero_extend = {48'd0, d[15:0]};
            OP_WIDTH_4_REG: zero_extend = {32'd0, d[31:0]};
            default:        zero_extend = d;
        endcase
    endfunction

endpackage

// File: rtl/load_ctrl_sign_extend.sv
// rtl/load_ctrl_sign_extend.sv - sign-extends the low 1/2/4/8 bytes of a beat to register width
module load_ctrl_sign_extend
    import load_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] data,
    input  op_width_t        width,
    output logic [REG_W-1:0] result
);

    always_comb begin
        result = data;
        case (width)
            OP_WIDTH_1_REG: result = {{56{data[7]}},  data[7:0]};
            OP_WIDTH_2_REG: result = {{48{data[15]}}, data[15:0]};
            OP_WIDTH_4_REG: result = {{32{data[31]}}, data[31:0]};
            default:        result = data;
        endcase
    end

endmodule

// File: rtl/load_ctrl.sv
// rtl/load_ctrl.sv - single-beat AXI4 read engine for core loads with alignment and extension
module load_ctrl
    import load_ctrl_pkg::*;
#(
    parameter int         ADDR_W = 64,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  op_width_t         req_width,
    input  logic              req_unsigned,
    output logic              busy,
    output logic              resp_valid,
    output logic [REG_W-1:0]  resp_data,
    output logic              resp_err,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic [7:0]        arlen,
    output logic [1:0]        arburst,
    output logic [3:0]        arid,
    input  logic              rvalid,
    output logic              rready,
    input  logic [63:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic [3:0]        rid
);

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    op_width_t         width_q;
    logic              unsigned_q;
    logic              err_q;
    logic [REG_W-1:0]  beat_q;
    logic [REG_W-1:0]  sext;
    logic              misaligned;
    logic              accept;
    logic              unused_rlast;

    assign unused_rlast = rlast;
    assign misaligned   = |(req_addr[2:0] & align_mask(req_width));
    assign accept       = (state_q == LD_IDLE) && req_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= LD_IDLE;
            addr_q     <= '0;
            width_q    <= OP_WIDTH_1_REG;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            beat_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= req_addr;
                width_q    <= req_width;
                unsigned_q <= req_unsigned;
                err_q      <= misaligned;
                beat_q     <= '0;
            end
            if ((state_q == LD_DATA) && rvalid) begin
                // Byte lane of the request lands at bit 0; extension discards the upper bytes.
                beat_q <= rdata >> {addr_q[2:0], 3'b000};
                err_q  <= (rresp != AXI_RESP_OKAY) || (rid != AXI_ID);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_IDLE: if (req_valid) state_d = misaligned ? LD_RESP : LD_ADDR;
            LD_ADDR: if (arready)   state_d = LD_DATA;
            LD_DATA: if (rvalid)    state_d = LD_RESP;
            LD_RESP:                state_d = LD_IDLE;
            default:                state_d = LD_IDLE;
        endcase
    end

    load_ctrl_sign_extend u_sign_extend (
        .data   (beat_q),
        .width  (width_q),
        .result (sext)
    );

    always_comb begin
        resp_data = '0;
        if ((state_q == LD_RESP) && !err_q) begin
            resp_data = unsigned_q ? zero_extend(beat_q, width_q) : sext;
        end
    end

    assign busy       = accept || (state_q == LD_ADDR) || (state_q == LD_DATA);
    assign resp_valid = (state_q == LD_RESP);
    assign resp_err   = (state_q == LD_RESP) && err_q;
    assign arvalid    = (state_q == LD_ADDR);
    assign rready     = (state_q == LD_DATA);
    assign araddr     = addr_q;
    assign arsize     = width_to_size(width_q);
    assign arlen      = 8'd0;
    assign arburst    = AXI_BURST_INCR;
    assign arid       = AXI_ID;

endmodule

// File: tb/tb_load_ctrl.sv
// tb/tb_load_ctrl.sv - randomized and directed self-checking bench for load_ctrl
module tb_load_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [63:0] req_addr;
    logic [1:0]  req_width;
    logic        req_unsigned;
    logic        busy;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        arvalid;
    logic        arready;
    logic [63:0] araddr;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    int tests = 0;
    int fails = 0;

    load_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_width    (req_width),
        .req_unsigned (req_unsigned),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .arvalid      (arvalid),
        .arready      (arready),
        .araddr       (araddr),
        .arsize       (arsize),
        .arlen        (arlen),
        .arburst      (arburst),
        .arid         (arid),
        .rvalid       (rvalid),
        .rready       (rready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rid          (rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference result from the load semantics: pick bytes, mask to size, extend.
    function automatic logic [63:0] model_data(input logic [63:0] addr, input int w, input bit uns,
                                               input logic [63:0] data, input bit err);
        int nbytes;
        logic [63:0] v;
        logic [63:0] mask;
        nbytes = 1 << w;
        v = data >> (8 * int'(addr[2:0]));
        if (nbytes < 8) begin
            mask = (64'd1 << (8 * nbytes)) - 64'd1;
            v = v & mask;
            if (!uns && v[8*nbytes-1]) v = v | ~mask;
        end
        return err ? 64'd0 : v;
    endfunction

    task automatic do_load(input string tag, input logic [63:0] addr, input int w, input bit uns,
                           input int arw, input int rw, input logic [63:0] data,
                           input logic [1:0] resp, input logic [3:0] id, input bit hold);
        bit mis;
        bit err;
        int exp_lat;
        int lat;
        int busy_n;
        int ar_n;
        int ar_bad;
        int ar_cnt;
        int r_cnt;
        bit ar_done;
        bit r_done;
        logic [63:0] got_d;
        logic        got_e;
        mis     = (int'(addr[2:0]) % (1 << w)) != 0;
        err     = mis || (resp != 2'b00) || (id != 4'd0);
        exp_lat = mis ? 1 : 3 + arw + rw;
        lat = -1; busy_n = 0; ar_n = 0; ar_bad = 0; ar_cnt = 0; r_cnt = 0;
        ar_done = 0; r_done = 0; got_d = '0; got_e = 1'b0;
        for (int c = 0; c < 60 && lat < 0; c++) begin
            req_valid    = (c == 0) || hold;
            req_addr     = addr;
            req_width    = 2'(w);
            req_unsigned = uns;
            arready      = (ar_cnt == arw);
            rvalid       = ar_done && !r_done && (r_cnt == rw);
            rdata        = rvalid ? data : {$urandom, $urandom};
            rresp        = rvalid ? resp : 2'($urandom);
            rlast        = rvalid;
            rid          = id;
            #1;
            if (busy) busy_n++;
            if (arvalid) begin
                ar_n++;
                if (araddr !== addr || arsize !== 3'(w) || arlen !== 8'd0 ||
                    arburst !== 2'b01 || arid !== 4'd0) ar_bad++;
            end
            if (resp_valid) begin
                lat   = c;
                got_d = resp_data;
                got_e = resp_err;
            end
            if (ar_done && !r_done) begin
                if (rvalid && rready) r_done = 1;
                else if (rready) r_cnt++;
            end
            if (arvalid && arready) ar_done = 1;
            else if (arvalid) ar_cnt++;
            @(negedge clk);
        end
        rvalid = 1'b0;
        if (!hold) req_valid = 1'b0;
        check({tag, "_lat"},  64'(lat), 64'(exp_lat));
        check({tag, "_data"}, got_d, model_data(addr, w, uns, data, err));
        check({tag, "_err"},  64'(got_e), 64'(err));
        check({tag, "_busy"}, 64'(busy_n), 64'(exp_lat));
        check({tag, "_arn"},  64'(ar_n), mis ? 64'd0 : 64'(arw + 1));
        check({tag, "_arok"}, 64'(ar_bad), 64'd0);
    endtask

    initial begin
        int stray;
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_width = '0; req_unsigned = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
        repeat (3) @(negedge clk);
        check("rst_ctl",   {59'd0, busy, resp_valid, resp_err, arvalid, rready}, 64'd0);
        check("rst_data",  resp_data, 64'd0);
        check("rst_addr",  araddr, 64'd0);
        check("rst_size",  64'(arsize), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_load("lb",  64'h1003, 0, 0, 0, 0, 64'h00000000_80000000, 2'b00, 4'd0, 0);
        do_load("lhu", 64'h2006, 1, 1, 3, 0, 64'hBEEF_0000_0000_0000, 2'b00, 4'd0, 0);
        do_load("lw_mis", 64'h3002, 2, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 2'b00, 4'd0, 0);
        do_load("ld_slv", 64'h4000, 3, 0, 0, 4, 64'h0123_4567_89AB_CDEF, 2'b10, 4'd0, 0);
        do_load("ld_rid", 64'h4008, 3, 0, 1, 1, 64'h0123_4567_89AB_CDEF, 2'b00, 4'd3, 0);
        check("lb_ref", model_data(64'h1003, 0, 0, 64'h80000000, 0), 64'hFFFFFFFF_FFFFFF80);

        // Reset while waiting for read data drops the transaction.
        req_valid = 1'b1; req_addr = 64'h5000; req_width = 2'd3; req_unsigned = 1'b0;
        arready = 1'b1; rvalid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rstmid_rready", 64'(rready), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_ctl",  {59'd0, busy, resp_valid, resp_err, arvalid, rready}, 64'd0);
        check("rstmid_data", resp_data, 64'd0);
        check("rstmid_size", 64'(arsize), 64'd0);
        rvalid = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF; rresp = 2'b00; rid = 4'd0;
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rvalid = 1'b0;
            #1;
            if (resp_valid || busy) stray++;
        end
        check("rstmid_stray", 64'(stray), 64'd0);
        @(negedge clk);

        // Back-to-back LWU with req_valid held across both requests.
        do_load("b2b0", 64'h6004, 2, 1, 0, 0, 64'h8765_4321_FEDC_BA98, 2'b00, 4'd0, 1);
        do_load("b2b1", 64'h6008, 2, 1, 1, 0, 64'h0000_0000_F00D_CAFE, 2'b00, 4'd0, 1);
        req_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [63:0] a;
            logic [63:0] d;
            logic [1:0]  rr;
            logic [3:0]  id;
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
            d  = {$urandom, $urandom};
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            id = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            do_load("rnd", a, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d, rr, id, 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
